// File: rtl/video_timing_gen.sv
// Raster timing generator for the RGB pixel clock domain.
// Walks hc/vc over back porch, active, front porch, sync and turns the
// count into x/y, de, hs, vs and line/frame start pulses. de/hs/vs can be
// pushed back by SYNC_DELAY cycles to line up with a downstream pixel
// pipeline; x/y and the start pulses stay at stage-1 timing.
module video_timing_gen #(
   parameter int HOR_ACTIVE_PIXELS      = 1280,
   parameter int HOR_BACK_PORCH_PIXELS  = 220,
   parameter int HOR_FRONT_PORCH_PIXELS = 110,
   parameter int HOR_SYNC_PIXELS        = 40,
   parameter int VER_ACTIVE_PIXELS      = 720,
   parameter int VER_BACK_PORCH_PIXELS  = 20,
   parameter int VER_FRONT_PORCH_PIXELS = 5,
   parameter int VER_SYNC_PIXELS        = 5,
   parameter int HS_ACTIVE_HIGH         = 1,
   parameter int VS_ACTIVE_HIGH         = 1,
   parameter int SYNC_DELAY             = 0,
   localparam int X_WIDTH = (HOR_ACTIVE_PIXELS > 1) ? $clog2(HOR_ACTIVE_PIXELS) : 1,
   localparam int Y_WIDTH = (VER_ACTIVE_PIXELS > 1) ? $clog2(VER_ACTIVE_PIXELS) : 1
) (
   input  logic               clk_rgb,
   input  logic               rst,
   input  logic               en,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               de,
   output logic               hs,
   output logic               vs,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = HOR_BACK_PORCH_PIXELS + HOR_ACTIVE_PIXELS +
                            HOR_FRONT_PORCH_PIXELS + HOR_SYNC_PIXELS;
   localparam int V_TOTAL = VER_BACK_PORCH_PIXELS + VER_ACTIVE_PIXELS +
                            VER_FRONT_PORCH_PIXELS + VER_SYNC_PIXELS;
   localparam int HC_W = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VC_W = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   // Region boundaries in counter width so every compare is width-matched.
   localparam logic [HC_W-1:0] H_ACT_BEG  = HC_W'(HOR_BACK_PORCH_PIXELS);
   localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(HOR_BACK_PORCH_PIXELS + HOR_ACTIVE_PIXELS);
   localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(HOR_BACK_PORCH_PIXELS + HOR_ACTIVE_PIXELS +
                                                  HOR_FRONT_PORCH_PIXELS);
   localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT_BEG  = VC_W'(VER_BACK_PORCH_PIXELS);
   localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(VER_BACK_PORCH_PIXELS + VER_ACTIVE_PIXELS);
   localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(VER_BACK_PORCH_PIXELS + VER_ACTIVE_PIXELS +
                                                  VER_FRONT_PORCH_PIXELS);
   localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);

   // Asserted sync level and its idle (reset) complement.
   localparam logic HS_POL  = (HS_ACTIVE_HIGH != 0);
   localparam logic VS_POL  = (VS_ACTIVE_HIGH != 0);
   localparam logic HS_IDLE = ~HS_POL;
   localparam logic VS_IDLE = ~VS_POL;

   // Refuse to elaborate a degenerate raster or an out-of-range delay.
   if (HOR_ACTIVE_PIXELS < 1 || HOR_BACK_PORCH_PIXELS < 1 ||
       HOR_FRONT_PORCH_PIXELS < 1 || HOR_SYNC_PIXELS < 1 ||
       VER_ACTIVE_PIXELS < 1 || VER_BACK_PORCH_PIXELS < 1 ||
       VER_FRONT_PORCH_PIXELS < 1 || VER_SYNC_PIXELS < 1 ||
       SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_cfg
      $fatal(1, "video_timing_gen: porch/sync/active must be >= 1 and SYNC_DELAY in 0..15");
   end

   logic [HC_W-1:0] hc;
   logic [VC_W-1:0] vc;

   logic               h_act, v_act, h_sync, v_sync, act;
   logic [X_WIDTH-1:0] x_nxt;
   logic [Y_WIDTH-1:0] y_nxt;
   logic               ls_nxt, fs_nxt, hs_nxt, vs_nxt;

   // Stage 0 of the delay line is the stage-1 register itself.
   logic [SYNC_DELAY:0] de_pipe, hs_pipe, vs_pipe;

   // Raster counters: hc runs every enabled clock, vc steps on hc wrap.
   always_ff @(posedge clk_rgb or posedge rst) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + VC_W'(1);
         end else begin
            hc <= hc + HC_W'(1);
         end
      end
   end

   // Region decode and next stage-1 values from the current count.
   always_comb begin
      h_act  = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
      v_act  = (vc >= V_ACT_BEG) && (vc < V_ACT_END);
      h_sync = (hc >= H_SYNC_BEG);
      v_sync = (vc >= V_SYNC_BEG);
      act    = h_act && v_act;
      x_nxt  = '0;
      y_nxt  = '0;
      if (act) begin
         x_nxt = X_WIDTH'(hc - H_ACT_BEG);
         y_nxt = Y_WIDTH'(vc - V_ACT_BEG);
      end
      // x==0 inside the active window is exactly hc==HB.
      ls_nxt = act && (hc == H_ACT_BEG);
      fs_nxt = ls_nxt && (vc == V_ACT_BEG);
      hs_nxt = ~(h_sync ^ HS_POL);
      vs_nxt = ~(v_sync ^ VS_POL);
   end

   // Stage-1 registers and the de/hs/vs delay line, all frozen by en=0.
   always_ff @(posedge clk_rgb or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         de_pipe     <= '0;
         hs_pipe     <= {(SYNC_DELAY+1){HS_IDLE}};
         vs_pipe     <= {(SYNC_DELAY+1){VS_IDLE}};
      end else if (en) begin
         x           <= x_nxt;
         y           <= y_nxt;
         line_start  <= ls_nxt;
         frame_start <= fs_nxt;
         de_pipe[0]  <= act;
         hs_pipe[0]  <= hs_nxt;
         vs_pipe[0]  <= vs_nxt;
         for (int i = 1; i <= SYNC_DELAY; i++) begin
            de_pipe[i] <= de_pipe[i-1];
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
         end
      end
   end

   assign de = de_pipe[SYNC_DELAY];
   assign hs = hs_pipe[SYNC_DELAY];
   assign vs = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four instances (small raster in three
// polarity/delay variants plus the default 1280x720 raster) share clock,
// reset and a randomized enable. Expected outputs come from the raster
// arithmetic: after n enabled edges the stage-1 outputs describe raster
// position n-1, and de/hs/vs describe position n-1-SYNC_DELAY.
module tb_video_timing_gen;

   typedef struct {
      int ha, hb, hf, hsw, va, vb, vf, vsw, hp, vp, sd;
   } cfg_t;

   typedef struct {
      int x, y, de, hs, vs, ls, fs;
   } out_t;

   logic clk_rgb, rst, en;

   logic [1:0]  sm_x,  dl_x,  pl_x;
   logic [1:0]  sm_y,  dl_y,  pl_y;
   logic [10:0] df_x;
   logic [9:0]  df_y;
   logic sm_de, sm_hs, sm_vs, sm_ls, sm_fs;
   logic dl_de, dl_hs, dl_vs, dl_ls, dl_fs;
   logic pl_de, pl_hs, pl_vs, pl_ls, pl_fs;
   logic df_de, df_hs, df_vs, df_ls, df_fs;

   int     tests = 0;
   int     fails = 0;
   longint n     = 0;   // enabled edges since reset release
   cfg_t   c_sm, c_dl, c_pl, c_df;

   video_timing_gen #(
      .HOR_ACTIVE_PIXELS(4), .HOR_BACK_PORCH_PIXELS(2), .HOR_FRONT_PORCH_PIXELS(1), .HOR_SYNC_PIXELS(1),
      .VER_ACTIVE_PIXELS(3), .VER_BACK_PORCH_PIXELS(1), .VER_FRONT_PORCH_PIXELS(1), .VER_SYNC_PIXELS(1),
      .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .SYNC_DELAY(0)
   ) u_sm (
      .clk_rgb(clk_rgb), .rst(rst), .en(en), .x(sm_x), .y(sm_y), .de(sm_de), .hs(sm_hs), .vs(sm_vs),
      .line_start(sm_ls), .frame_start(sm_fs)
   );

   video_timing_gen #(
      .HOR_ACTIVE_PIXELS(4), .HOR_BACK_PORCH_PIXELS(2), .HOR_FRONT_PORCH_PIXELS(1), .HOR_SYNC_PIXELS(1),
      .VER_ACTIVE_PIXELS(3), .VER_BACK_PORCH_PIXELS(1), .VER_FRONT_PORCH_PIXELS(1), .VER_SYNC_PIXELS(1),
      .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .SYNC_DELAY(3)
   ) u_dl (
      .clk_rgb(clk_rgb), .rst(rst), .en(en), .x(dl_x), .y(dl_y), .de(dl_de), .hs(dl_hs), .vs(dl_vs),
      .line_start(dl_ls), .frame_start(dl_fs)
   );

   video_timing_gen #(
      .HOR_ACTIVE_PIXELS(4), .HOR_BACK_PORCH_PIXELS(2), .HOR_FRONT_PORCH_PIXELS(1), .HOR_SYNC_PIXELS(1),
      .VER_ACTIVE_PIXELS(3), .VER_BACK_PORCH_PIXELS(1), .VER_FRONT_PORCH_PIXELS(1), .VER_SYNC_PIXELS(1),
      .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0), .SYNC_DELAY(0)
   ) u_pl (
      .clk_rgb(clk_rgb), .rst(rst), .en(en), .x(pl_x), .y(pl_y), .de(pl_de), .hs(pl_hs), .vs(pl_vs),
      .line_start(pl_ls), .frame_start(pl_fs)
   );

   video_timing_gen u_df (
      .clk_rgb(clk_rgb), .rst(rst), .en(en), .x(df_x), .y(df_y), .de(df_de), .hs(df_hs), .vs(df_vs),
      .line_start(df_ls), .frame_start(df_fs)
   );

   initial begin
      clk_rgb = 1'b0;
      forever #5 clk_rgb = ~clk_rgb;
   end

   // Outputs after k enabled edges, with no delay line applied.
   function automatic out_t stage1(input cfg_t c, input longint k);
      out_t   o;
      longint ht, vt, p, h, v;
      o.x = 0; o.y = 0; o.de = 0; o.ls = 0; o.fs = 0;
      o.hs = (c.hp != 0) ? 0 : 1;
      o.vs = (c.vp != 0) ? 0 : 1;
      if (k <= 0) return o;
      ht = c.hb + c.ha + c.hf + c.hsw;
      vt = c.vb + c.va + c.vf + c.vsw;
      p  = (k - 1) % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      if (h >= c.hb && h < c.hb + c.ha && v >= c.vb && v < c.vb + c.va) begin
         o.de = 1;
         o.x  = int'(h - c.hb);
         o.y  = int'(v - c.vb);
         o.ls = (h == c.hb) ? 1 : 0;
         o.fs = (h == c.hb && v == c.vb) ? 1 : 0;
      end
      if (h >= c.hb + c.ha + c.hf) o.hs = (c.hp != 0) ? 1 : 0;
      if (v >= c.vb + c.va + c.vf) o.vs = (c.vp != 0) ? 1 : 0;
      return o;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s n=%0d got=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   task automatic chk_inst(input string nm, input cfg_t c, input int ox, input int oy,
                           input int ode, input int ohs, input int ovs, input int ols, input int ofs);
      out_t a, d;
      a = stage1(c, n);
      d = stage1(c, n - c.sd);
      chk({nm, ".x"},  ox,  a.x);
      chk({nm, ".y"},  oy,  a.y);
      chk({nm, ".ls"}, ols, a.ls);
      chk({nm, ".fs"}, ofs, a.fs);
      chk({nm, ".de"}, ode, d.de);
      chk({nm, ".hs"}, ohs, d.hs);
      chk({nm, ".vs"}, ovs, d.vs);
   endtask

   task automatic check_all();
      chk_inst("sm", c_sm, int'(sm_x), int'(sm_y), int'(sm_de), int'(sm_hs), int'(sm_vs), int'(sm_ls), int'(sm_fs));
      chk_inst("dl", c_dl, int'(dl_x), int'(dl_y), int'(dl_de), int'(dl_hs), int'(dl_vs), int'(dl_ls), int'(dl_fs));
      chk_inst("pl", c_pl, int'(pl_x), int'(pl_y), int'(pl_de), int'(pl_hs), int'(pl_vs), int'(pl_ls), int'(pl_fs));
      chk_inst("df", c_df, int'(df_x), int'(df_y), int'(df_de), int'(df_hs), int'(df_vs), int'(df_ls), int'(df_fs));
   endtask

   // One clock: count the edge if it was enabled, then sample 1 time unit later.
   task automatic step();
      @(posedge clk_rgb);
      if (en && !rst) n++;
      #1;
      check_all();
   endtask

   initial begin
      c_sm = '{ha:4, hb:2, hf:1, hsw:1, va:3, vb:1, vf:1, vsw:1, hp:1, vp:1, sd:0};
      c_dl = '{ha:4, hb:2, hf:1, hsw:1, va:3, vb:1, vf:1, vsw:1, hp:1, vp:1, sd:3};
      c_pl = '{ha:4, hb:2, hf:1, hsw:1, va:3, vb:1, vf:1, vsw:1, hp:0, vp:0, sd:0};
      c_df = '{ha:1280, hb:220, hf:110, hsw:40, va:720, vb:20, vf:5, vsw:5, hp:1, vp:1, sd:0};

      // Held in reset: everything at idle levels.
      rst = 1'b1;
      en  = 1'b1;
      #1;
      check_all();
      repeat (3) step();

      // Free-running enable over several small frames.
      rst = 1'b0;
      repeat (200) step();

      // Random enable pattern.
      repeat (300) begin
         en = 1'($urandom_range(0, 1));
         step();
      end

      // Enable toggled every cycle.
      repeat (100) begin
         en = ~en;
         step();
      end

      // Asynchronous reset between clock edges, mid-line on every instance.
      en = 1'b1;
      repeat (1000) step();
      #2;
      rst = 1'b1;
      n   = 0;
      #1;
      check_all();
      step();
      rst = 1'b0;

      // Long run so the default raster reaches its first active pixel again.
      repeat (33400) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
